mips_dmem_responder: RTL

//  Memory-side responder for the MIPS CPU data-memory port: accepts one load/store request at a

---
 rtl/mips_dmem_responder_pkg.sv | 23 ++
 rtl/mips_dmem_responder_if.sv | 26 ++
 rtl/mips_dmem_responder_word_array.sv | 28 ++
 rtl/mips_dmem_responder.sv | 118 +++++++++++
 4 files changed

// File: rtl/mips_dmem_responder_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM encoding,
// word-offset constant and a width helper used for counter and index sizing.
package mips_dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_OFFSET = 2;

    // Bits needed to hold values 0 .. value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between the CPU data port (master) and the
// data-memory responder (slave).
interface mips_dmem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_dmem_responder_word_array.sv
// Word storage for the data-memory responder: synchronous write,
// combinational read, asynchronous active-low clear of every word.
module mips_dmem_responder_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    parameter int MEM_AW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [MEM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// registered response held until the initiator consumes it.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready for a request; accept captures we/addr/wdata
//   ST_WAIT | counting down wait states; access performed when count is 0
//   ST_RESP | response presented; held until rsp_ready
module mips_dmem_responder
    import mips_dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_dmem_responder_if.slave     bus
);
    localparam int CNT_W  = clog2_min1(WAIT_STATES + 1);
    localparam int IDX_W  = ADDR_WIDTH - WORD_OFFSET;
    localparam int MEM_AW = clog2_min1(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cap_we_q;
    logic [ADDR_WIDTH-1:0] cap_addr_q;
    logic [DATA_WIDTH-1:0] cap_wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  access;
    logic                  addr_err;
    logic                  mem_we;
    logic [IDX_W-1:0]      cap_idx;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    assign cap_idx  = cap_addr_q[ADDR_WIDTH-1:WORD_OFFSET];
    assign addr_err = (cap_addr_q[WORD_OFFSET-1:0] != '0) || (int'(cap_idx) >= MEM_DEPTH);
    assign mem_addr = MEM_AW'(cap_idx);
    assign mem_we   = access && cap_we_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_we_q    <= bus.req_we;
                cap_addr_q  <= bus.req_addr;
                cap_wdata_q <= bus.req_wdata;
            end
            // Response is frozen at WAIT exit so it stays stable under backpressure.
            if (access) begin
                rdata_q <= (addr_err || cap_we_q) ? '0 : mem_rdata;
                err_q   <= addr_err;
            end
        end
    end

    mips_dmem_responder_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_AW     (MEM_AW)
    ) u_word_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (cap_wdata_q),
        .rdata (mem_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
